// File: rtl/tx_rate_gen_pkg.sv
// -----------------------------------------------------------------------------
// tx_rate_gen_pkg
// Shared definitions for the TX cadence generator: FSM state encoding, rate and
// cadence codes, frame counter width and the default frame length.
// -----------------------------------------------------------------------------
package tx_rate_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic RATE_HD  = 1'b0;
    localparam logic RATE_3G  = 1'b1;
    localparam logic CAD_INT  = 1'b0;
    localparam logic CAD_FRAC = 1'b1;

    localparam int unsigned DEF_PDROP_PERIOD = 1001;
    localparam int          FCNT_W           = 10;

endpackage

// File: rtl/tx_rate_gen_slot_cnt.sv
// -----------------------------------------------------------------------------
// tx_slot_cnt
// Slot / frame counter. Decides, once per enabled cycle, whether the cycle
// being decided is a data slot and which frame position it occupies.
//
// Ports
//   ref_clk  in   clock
//   rst      in   synchronous active-high reset
//   tg_hdn   in   applied rate (1 = every cycle is a slot, 0 = every other)
//   clear    in   restart cadence: this decision is slot 0 of a new frame
//   ce       in   advance enable
//   slot     out  current decision is a slot
//   fcnt     out  frame position of the current decision
// -----------------------------------------------------------------------------
module tx_slot_cnt
    import tx_rate_gen_pkg::*;
#(
    parameter int unsigned pdrop_period = DEF_PDROP_PERIOD
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              tg_hdn,
    input  logic              clear,
    input  logic              ce,
    output logic              slot,
    output logic [FCNT_W-1:0] fcnt
);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(pdrop_period - 1);

    logic              phase_q, phase_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              phase_eff;

    // A clear makes the cycle being decided behave as freshly reset state, so
    // the first decision after a clear is always slot 0.
    always_comb begin
        phase_eff = clear ? 1'b0 : phase_q;
        fcnt      = clear ? '0 : fcnt_q;
        slot      = (tg_hdn == RATE_3G) || !phase_eff;
        phase_d   = phase_q;
        fcnt_d    = fcnt_q;
        if (ce) begin
            phase_d = !phase_eff;
            if (slot) begin
                fcnt_d = (fcnt == FCNT_LAST) ? '0 : fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: rtl/tx_rate_gen.sv
// -----------------------------------------------------------------------------
// tx_rate_gen
// TX data-slot cadence generator. Produces tx_ce slot enables at 3G (every
// cycle) or HD (every other cycle) rate, in integer cadence or fractional
// cadence (the last slot of every pdrop_period-slot frame is dropped).
// Reconfiguration while running is deferred to the next frame boundary.
//
// Optional build macro: FRAC_DROP_CNT_EN adds the drop_cnt output, a
// saturating 16-bit count of dropped slots.
//
// Ports
//   ref_clk        in   clock
//   rst            in   synchronous active-high reset
//   ce             in   global clock enable
//   cfg_valid      in   configuration offer
//   cfg_tg_hdn     in   requested rate (0 HD, 1 3G)
//   cfg_frac_intn  in   requested cadence (0 integer, 1 fractional)
//   cfg_ready      out  configuration accept
//   tx_ce          out  data-slot enable
//   frame_tc       out  pulse on the last slot of each frame
//   frac_intn      out  applied cadence
//   tg_hdn         out  applied rate
//   out_valid      out  cadence generation active
//   drop_cnt       out  dropped slot count (FRAC_DROP_CNT_EN only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no cadence; waiting for the first configuration
// ST_RUN  | cadence running; new configuration may be offered
// ST_PEND | new configuration captured; applied at the next frame_tc
// -----------------------------------------------------------------------------
module tx_rate_gen
    import tx_rate_gen_pkg::*;
#(
    parameter int unsigned pdrop_period = DEF_PDROP_PERIOD
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        cfg_valid,
    input  logic        cfg_tg_hdn,
    input  logic        cfg_frac_intn,
    output logic        cfg_ready,
    output logic        tx_ce,
    output logic        frame_tc,
    output logic        frac_intn,
    output logic        tg_hdn,
    output logic        out_valid
`ifdef FRAC_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(pdrop_period - 1);

    state_t            state_q, state_d;
    logic              tg_hdn_q, tg_hdn_d;
    logic              frac_q, frac_d;
    logic              sh_tg_q, sh_tg_d;
    logic              sh_frac_q, sh_frac_d;
    logic              tx_ce_q, tx_ce_d;
    logic              frame_tc_q, frame_tc_d;

    logic              running, hs, swap, clear, cnt_ce;
    logic              slot, last_slot, drop_slot;
    logic [FCNT_W-1:0] fcnt;

    assign running   = (state_q != ST_IDLE);
    assign cfg_ready = (state_q != ST_PEND);
    assign hs        = cfg_valid & cfg_ready & ce;
    // The pending configuration takes over in the cycle frame_tc is visible.
    assign swap      = (state_q == ST_PEND) & frame_tc_q & ce;
    assign clear     = ((state_q == ST_IDLE) & hs) | swap;
    assign cnt_ce    = ce & (running | clear);

    tx_slot_cnt #(
        .pdrop_period (pdrop_period)
    ) u_slot_cnt (
        .ref_clk (ref_clk),
        .rst     (rst),
        .tg_hdn  (tg_hdn_q),
        .clear   (clear),
        .ce      (cnt_ce),
        .slot    (slot),
        .fcnt    (fcnt)
    );

    assign last_slot = (fcnt == FCNT_LAST);
    assign drop_slot = (frac_q == CAD_FRAC) & last_slot;

    always_comb begin
        state_d    = state_q;
        tg_hdn_d   = tg_hdn_q;
        frac_d     = frac_q;
        sh_tg_d    = sh_tg_q;
        sh_frac_d  = sh_frac_q;
        tx_ce_d    = tx_ce_q;
        frame_tc_d = frame_tc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    tg_hdn_d = cfg_tg_hdn;
                    frac_d   = cfg_frac_intn;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    sh_tg_d   = cfg_tg_hdn;
                    sh_frac_d = cfg_frac_intn;
                    state_d   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (swap) begin
                    tg_hdn_d = sh_tg_q;
                    frac_d   = sh_frac_q;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ce) begin
            tx_ce_d    = cnt_ce & slot & !drop_slot;
            frame_tc_d = cnt_ce & slot & last_slot;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tg_hdn_q   <= RATE_HD;
            frac_q     <= CAD_INT;
            sh_tg_q    <= RATE_HD;
            sh_frac_q  <= CAD_INT;
            tx_ce_q    <= 1'b0;
            frame_tc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tg_hdn_q   <= tg_hdn_d;
            frac_q     <= frac_d;
            sh_tg_q    <= sh_tg_d;
            sh_frac_q  <= sh_frac_d;
            tx_ce_q    <= tx_ce_d;
            frame_tc_q <= frame_tc_d;
        end
    end

    assign tx_ce     = tx_ce_q & ce;
    assign frame_tc  = frame_tc_q & ce;
    assign tg_hdn    = tg_hdn_q;
    assign frac_intn = frac_q;
    assign out_valid = running;

`ifdef FRAC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (cnt_ce & slot & drop_slot & (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tx_rate_gen.sv
// -----------------------------------------------------------------------------
// tb_tx_rate_gen
// Self-checking bench for tx_rate_gen. The reference model tracks the mode and
// the number of enabled cycles since the cadence started, and derives slot,
// frame position and drop from plain arithmetic on that count.
// -----------------------------------------------------------------------------
module tb_tx_rate_gen;

    localparam int P = 1001;

    logic ref_clk = 1'b0;
    logic rst = 1'b1, ce = 1'b0, cfg_valid = 1'b0, cfg_tg_hdn = 1'b0, cfg_frac_intn = 1'b0;
    logic cfg_ready, tx_ce, frame_tc, frac_intn, tg_hdn, out_valid;
`ifdef FRAC_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    tx_rate_gen #(.pdrop_period(P)) dut (
        .ref_clk       (ref_clk),
        .rst           (rst),
        .ce            (ce),
        .cfg_valid     (cfg_valid),
        .cfg_tg_hdn    (cfg_tg_hdn),
        .cfg_frac_intn (cfg_frac_intn),
        .cfg_ready     (cfg_ready),
        .tx_ce         (tx_ce),
        .frame_tc      (frame_tc),
        .frac_intn     (frac_intn),
        .tg_hdn        (tg_hdn),
        .out_valid     (out_valid)
`ifdef FRAC_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 ref_clk = ~ref_clk;

    int checks = 0;
    int failures = 0;

    // model state: mode 0 idle, 1 run, 2 pend; edges = enabled edges since cadence start
    int       m_mode = 0;
    int       m_edges = 0;
    bit       m_tg = 0, m_frac = 0, m_sh_tg = 0, m_sh_frac = 0;
    int       m_drops = 0;
    bit [5:0] m_exp;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    // {tx_ce, frame_tc} shown in the output cycle n (n>=1) after cadence start
    function automatic bit [1:0] cad(input int n, input bit tg, input bit frac);
        int d, s, pos;
        bit sl;
        d = n - 1;
        if (tg) begin
            sl = 1'b1;
            s  = d;
        end else begin
            sl = (d % 2 == 0);
            s  = d / 2;
        end
        pos = s % P;
        return {sl && !(frac && pos == P - 1), sl && pos == P - 1};
    endfunction

    task automatic model_step(input bit r, input bit c, input bit v, input bit t, input bit f);
        bit [1:0] cur, nxt;
        bit       hs, ftc_pre, ov, rdy;
        cur     = (m_mode != 0) ? cad(m_edges, m_tg, m_frac) : 2'b00;
        ftc_pre = c && cur[0];
        hs      = c && v && (m_mode != 2);
        if (r) begin
            m_mode = 0; m_edges = 0; m_tg = 0; m_frac = 0;
            m_sh_tg = 0; m_sh_frac = 0; m_drops = 0;
        end else if (c) begin
            if (m_mode == 0) begin
                if (hs) begin
                    m_tg = t; m_frac = f; m_mode = 1; m_edges = 1;
                end
            end else if (m_mode == 2 && ftc_pre) begin
                m_tg = m_sh_tg; m_frac = m_sh_frac; m_mode = 1; m_edges = 1;
            end else begin
                nxt = cad(m_edges + 1, m_tg, m_frac);
                if (m_frac && nxt[0] && m_drops < 65535) m_drops++;
                m_edges++;
                if (m_mode == 1 && hs) begin
                    m_sh_tg = t; m_sh_frac = f; m_mode = 2;
                end
            end
        end
        ov  = (m_mode != 0);
        rdy = (m_mode != 2);
        cur = ov ? cad(m_edges, m_tg, m_frac) : 2'b00;
        m_exp = {rdy, ov, c && cur[1], c && cur[0], m_tg, m_frac};
    endtask

    // Apply inputs across one edge and compare every output with the model.
    task automatic step(input bit r, input bit c, input bit v, input bit t, input bit f);
        rst = r; ce = c; cfg_valid = v; cfg_tg_hdn = t; cfg_frac_intn = f;
        model_step(r, c, v, t, f);
        @(posedge ref_clk);
        #1;
        check("model_outputs", int'({cfg_ready, out_valid, tx_ce, frame_tc, tg_hdn, frac_intn}), int'(m_exp));
`ifdef FRAC_DROP_CNT_EN
        check("model_drop_cnt", int'(drop_cnt), m_drops);
`endif
    endtask

    typedef struct {
        bit       r, c, v, t, f;
        bit [5:0] exp;   // {cfg_ready, out_valid, tx_ce, frame_tc, tg_hdn, frac_intn}
    } vec_t;

    vec_t tbl[10];

    initial begin
        int ntx, bad, en_off, first_zero, first_ftc;
        int dq[$];
        int fq[$];
        int exp3[3];
        int exp2[2];

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b100000};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111011};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111011};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111011};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b011011};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b011011};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].t, tbl[i].f);
            check($sformatf("table_%0d", i),
                  int'({cfg_ready, out_valid, tx_ce, frame_tc, tg_hdn, frac_intn}), int'(tbl[i].exp));
        end

        // Fractional 3G: 3003 cycles from the first slot, three drops.
        step(1, 1, 0, 0, 0);
        ntx = 0; dq.delete(); fq.delete();
        for (int off = 0; off < 3003; off++) begin
            if (off == 0) step(0, 1, 1, 1, 1);
            else          step(0, 1, 0, 0, 0);
            if (tx_ce) ntx++;
            else       dq.push_back(off);
            if (frame_tc) fq.push_back(off);
        end
        exp3 = '{1000, 2001, 3002};
        check("frac3g_tx_count", ntx, 3000);
        check("frac3g_drop_num", dq.size(), 3);
        check("frac3g_ftc_num", fq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("frac3g_drop_pos_%0d", i), (i < dq.size()) ? dq[i] : -1, exp3[i]);
            check($sformatf("frac3g_ftc_pos_%0d", i), (i < fq.size()) ? fq[i] : -1, exp3[i]);
        end
        for (int i = 0; i < 2002; i++) step(0, 1, 0, 0, 0);
`ifdef FRAC_DROP_CNT_EN
        check("drop_cnt_5_frames", int'(drop_cnt), 5);
`endif

        // Integer HD: alternate-cycle slots, frame_tc every 2002 cycles.
        step(1, 1, 0, 0, 0);
        bad = 0; ntx = 0; fq.delete();
        for (int off = 0; off < 4005; off++) begin
            if (off == 0) step(0, 1, 1, 0, 0);
            else          step(0, 1, 0, 0, 0);
            if (tx_ce) ntx++;
            if (tx_ce != (off % 2 == 0)) bad++;
            if (frame_tc) fq.push_back(off);
        end
        exp2 = '{2000, 4002};
        check("hdint_alternation_errors", bad, 0);
        check("hdint_tx_count", ntx, 2003);
        check("hdint_ftc_num", fq.size(), 2);
        for (int i = 0; i < 2; i++)
            check($sformatf("hdint_ftc_pos_%0d", i), (i < fq.size()) ? fq[i] : -1, exp2[i]);

        // Mode switch 3G/int -> HD/frac at slot 400; offers held in PEND are ignored.
        step(1, 1, 0, 0, 0);
        bad = 0;
        for (int off = 0; off < 1004; off++) begin
            if (off == 0)        step(0, 1, 1, 1, 0);
            else if (off == 400) step(0, 1, 1, 0, 1);
            else                 step(0, 1, (off > 400 && off <= 700), 1, 0);
            if (off >= 400 && off <= 1000 && cfg_ready) bad++;
            if (off == 999)  check("switch_no_early_ftc", int'({frame_tc, tg_hdn}), 1);
            if (off == 1000) check("switch_ftc_old_cfg", int'({frame_tc, tx_ce, tg_hdn, frac_intn}), 4'b1110);
            if (off == 1001) check("switch_new_cfg_start", int'({cfg_ready, tx_ce, tg_hdn, frac_intn}), 4'b1101);
            if (off == 1002) check("switch_hd_gap", int'(tx_ce), 0);
            if (off == 1003) check("switch_hd_slot", int'(tx_ce), 1);
        end
        check("switch_ready_low_in_pend", bad, 0);

        // ce gating for 50 cycles mid-frame: drop position measured in enabled cycles.
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        bad = 0; en_off = 0; first_zero = -1; first_ftc = -1;
        for (int w = 1; w < 1100; w++) begin
            bit c;
            c = !(w >= 500 && w < 550);
            step(0, c, 0, 0, 0);
            if (!c) begin
                if (tx_ce || frame_tc) bad++;
            end else begin
                en_off++;
                if (!tx_ce && first_zero < 0) first_zero = en_off;
                if (frame_tc && first_ftc < 0) first_ftc = en_off;
            end
        end
        check("cegate_outputs_low", bad, 0);
        check("cegate_drop_pos", first_zero, 1000);
        check("cegate_ftc_pos", first_ftc, 1000);

        // Reset while PEND with a live handshake attempt.
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("pend_ready_low", int'(cfg_ready), 0);
        step(1, 1, 1, 1, 1);
        check("reset_in_pend", int'({cfg_ready, out_valid, tx_ce, frame_tc, tg_hdn, frac_intn}), 6'b100000);
        step(0, 1, 0, 0, 0);
        check("idle_after_reset", int'({cfg_ready, out_valid, tx_ce, frame_tc}), 4'b1000);

        // Randomized traffic against the model.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            bit r, c, v;
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 19) == 0);
            step(r, c, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
